// File: rtl/multicode_to_bcd.sv
// multicode_to_bcd: sequential 8421 / 84-2-1 / 2421 / excess-3 to packed 8421 BCD converter
//
// Converts one digit per cycle. Optional leading-zero blanking is enabled by
// defining the macro LEADING_ZERO_BLANK_EN; otherwise out_blank is tied to 0.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   in_valid       input word present
//   in_ready       high only while idle
//   in_code        DIGITS packed 4-bit codes, digit 0 in [3:0]
//   in_mode        00=8421, 01=84-2-1, 10=2421, 11=excess-3
//   out_valid      result word present (DONE state)
//   out_ready      consumer accepts result
//   out_bcd        packed BCD result, invalid digits forced to 4'hF
//   out_err        OR of out_err_mask
//   out_err_mask   per-digit invalid-code flags
//   out_blank      per-digit leading-zero blanking mask
module multicode_to_bcd #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_code,
    input  logic [1:0]            in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_err,
    output logic [DIGITS-1:0]     out_err_mask,
    output logic [DIGITS-1:0]     out_blank
);
    localparam int CW = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   code_q, code_d;
    logic [1:0]            mode_q, mode_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic [DIGITS-1:0]     err_q, err_d;

    // Returns {invalid, digit}; invalid codes yield 4'hF.
    function automatic logic [4:0] conv(input logic [3:0] c, input logic [1:0] m);
        logic [5:0] v;
        logic       ok;
        logic [3:0] d;
        // 84-2-1 value in 6-bit two's complement; negatives wrap above 9
        v  = {2'b0, c[3], 3'b0} + {3'b0, c[2], 2'b0} - {4'b0, c[1], 1'b0} - {5'b0, c[0]};
        ok = 1'b0;
        d  = c;
        case (m)
            2'b00: ok = c <= 4'd9;
            2'b01: begin
                ok = v <= 6'd9;
                d  = v[3:0];
            end
            2'b10: begin
                ok = c <= 4'd4 || c >= 4'd11;
                d  = c <= 4'd4 ? c : c - 4'd6;
            end
            default: begin
                ok = c >= 4'd3 && c <= 4'd12;
                d  = c - 4'd3;
            end
        endcase
        return ok ? {1'b0, d} : {1'b1, 4'hF};
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        mode_d  = mode_q;
        bcd_d   = bcd_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (in_valid) begin
                code_d  = in_code;
                mode_d  = in_mode;
                cnt_d   = '0;
                bcd_d   = '0;
                err_d   = '0;
                state_d = CONV;
            end
            CONV: begin
                for (int i = 0; i < DIGITS; i++)
                    if (cnt_q == CW'(i))
                        {err_d[i], bcd_d[4*i +: 4]} = conv(code_q[4*i +: 4], mode_q);
                cnt_d   = cnt_q + CW'(1);
                state_d = cnt_q == CW'(DIGITS - 1) ? DONE : CONV;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            mode_q  <= '0;
            bcd_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            mode_q  <= mode_d;
            bcd_q   <= bcd_d;
            err_q   <= err_d;
        end
    end

    assign in_ready     = state_q == IDLE;
    assign out_valid    = state_q == DONE;
    assign out_bcd      = out_valid ? bcd_q : '0;
    assign out_err_mask = out_valid ? err_q : '0;
    assign out_err      = |out_err_mask;

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              run;

    // Invalid digits read 4'hF, so a zero digit here is always a valid zero.
    // Unconverted digits still read 0, but the final CONV cycle sees all of them.
    always_comb begin
        blank_d = blank_q;
        run     = 1'b1;
        if (state_q == IDLE && in_valid)
            blank_d = '0;
        else if (state_q == CONV) begin
            blank_d = '0;
            for (int i = DIGITS - 1; i >= 1; i--) begin
                run        = run & (bcd_d[4*i +: 4] == 4'd0);
                blank_d[i] = run;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            blank_q <= '0;
        else
            blank_q <= blank_d;
    end

    assign out_blank = out_valid ? blank_q : '0;
`else
    assign out_blank = '0;
`endif

endmodule

// File: tb/tb_multicode_to_bcd.sv
// tb_multicode_to_bcd: scoreboard bench for multicode_to_bcd (DIGITS=4)
module tb_multicode_to_bcd;
    localparam int D = 4;
    localparam int W = 4 * D;

    typedef struct packed {
        logic [W-1:0] bcd;
        logic [D-1:0] mask;
        logic [D-1:0] blank;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_code = '0;
    logic [1:0]   in_mode = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_bcd;
    logic         out_err;
    logic [D-1:0] out_err_mask;
    logic [D-1:0] out_blank;

    int   tests = 0;
    int   fails = 0;
    exp_t q[$];

    // Valid code for each decimal digit 0..9, per mode
    logic [3:0] tbl [4][10] = '{
        '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9},
        '{4'h0, 4'h7, 4'h6, 4'h5, 4'h4, 4'hB, 4'hA, 4'h9, 4'h8, 4'hF},
        '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF},
        '{4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC}
    };

    multicode_to_bcd #(.DIGITS(D)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bcd(out_bcd), .out_err(out_err),
        .out_err_mask(out_err_mask), .out_blank(out_blank)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] code, input logic [1:0] m);
        exp_t       e;
        logic       run;
        logic [3:0] c;
        e = '0;
        for (int i = 0; i < D; i++) begin
            c = code[4*i +: 4];
            e.bcd[4*i +: 4] = 4'hF;
            e.mask[i] = 1'b1;
            for (int d = 0; d < 10; d++)
                if (tbl[m][d] == c) begin
                    e.bcd[4*i +: 4] = 4'(d);
                    e.mask[i] = 1'b0;
                end
        end
        run = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = D - 1; i >= 1; i--) begin
            run = run && !e.mask[i] && e.bcd[4*i +: 4] == 4'd0;
            e.blank[i] = run;
        end
`endif
        return e;
    endfunction

    task automatic run_word(input logic [W-1:0] code, input logic [1:0] m, input int hold, input bit early,
                            output int lat, output logic [W-1:0] bcd, output logic [D-1:0] mask,
                            output logic err, output logic [D-1:0] blank,
                            output bit busy_ok, output bit stable, output bit after_ok);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        q.push_back(model(code, m));
        in_valid = 1'b1; in_code = code; in_mode = m; out_ready = early;
        @(posedge clk); #1;
        in_valid = 1'b0; in_code = W'($urandom); in_mode = 2'($urandom);
        lat = 0; busy_ok = 1'b1;
        while (!out_valid && lat < 50) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk); #1; lat++;
        end
        bcd = out_bcd; mask = out_err_mask; err = out_err; blank = out_blank;
        stable = 1'b1;
        if (!early) begin
            repeat (hold) begin
                @(posedge clk); #1;
                if (out_bcd !== bcd || out_err_mask !== mask || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        after_ok = out_valid === 1'b0 && in_ready === 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++; if (out_bcd !== '0) begin fails++; $display("FAIL reset_out_bcd: got %h want 0", out_bcd); end
        tests++; if (out_err !== 1'b0 || out_err_mask !== '0) begin fails++; $display("FAIL reset_err: got %b/%b want 0/0", out_err, out_err_mask); end
        tests++; if (out_blank !== '0) begin fails++; $display("FAIL reset_blank: got %b want 0", out_blank); end
    endtask

    task automatic test_convert;
        logic [W-1:0] codes [6] = '{16'hF870, 16'h4567, 16'hFB04, 16'h0937, 16'h8001, 16'hA000};
        logic [1:0]   modes [6] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b00};
        int lat; logic [W-1:0] bcd; logic [D-1:0] mask, blank; logic err; bit b, s, a; exp_t e;
        for (int k = 0; k < 6; k++) begin
            run_word(codes[k], modes[k], 0, k[0], lat, bcd, mask, err, blank, b, s, a);
            e = q.pop_front();
            tests++; if (bcd !== e.bcd) begin fails++; $display("FAIL conv_bcd[%0d]: got %h want %h", k, bcd, e.bcd); end
            tests++; if (mask !== e.mask) begin fails++; $display("FAIL conv_mask[%0d]: got %b want %b", k, mask, e.mask); end
            tests++; if (err !== |e.mask) begin fails++; $display("FAIL conv_err[%0d]: got %b want %b", k, err, |e.mask); end
            tests++; if (lat !== D) begin fails++; $display("FAIL conv_latency[%0d]: got %0d want %0d", k, lat, D); end
            tests++; if (blank !== e.blank) begin fails++; $display("FAIL conv_blank[%0d]: got %b want %b", k, blank, e.blank); end
            tests++; if (!b || !a) begin fails++; $display("FAIL conv_handshake[%0d]: busy_ok %b after_ok %b want 1 1", k, b, a); end
        end
    endtask

    task automatic test_backpressure;
        int lat; logic [W-1:0] bcd; logic [D-1:0] mask, blank; logic err; bit b, s, a; exp_t e;
        run_word(16'h4567, 2'b11, 5, 1'b0, lat, bcd, mask, err, blank, b, s, a);
        e = q.pop_front();
        tests++; if (bcd !== e.bcd) begin fails++; $display("FAIL bp_bcd: got %h want %h", bcd, e.bcd); end
        tests++; if (!s) begin fails++; $display("FAIL bp_stable: got %b want 1", s); end
        tests++; if (!a) begin fails++; $display("FAIL bp_release: got %b want 1", a); end
    endtask

    task automatic test_reset_mid;
        int lat; logic [W-1:0] bcd; logic [D-1:0] mask, blank; logic err; bit b, s, a; bit seen; exp_t e;
        in_valid = 1'b1; in_code = 16'h4567; in_mode = 2'b11; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_bcd !== '0 || out_err_mask !== '0 || out_blank !== '0)
            begin fails++; $display("FAIL midrst_outputs: rdy %b vld %b bcd %h mask %b blank %b want 1 0 0 0 0", in_ready, out_valid, out_bcd, out_err_mask, out_blank); end
        seen = 1'b0;
        repeat (D + 2) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        tests++; if (seen) begin fails++; $display("FAIL midrst_no_output: got out_valid 1 want 0"); end
        out_ready = 1'b0;
        rst = 1'b1; in_valid = 1'b1; in_code = 16'h1234; in_mode = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_beats_valid: got in_ready %b want 1", in_ready); end
        run_word(16'h4567, 2'b11, 0, 1'b0, lat, bcd, mask, err, blank, b, s, a);
        e = q.pop_front();
        tests++; if (bcd !== e.bcd || lat !== D) begin fails++; $display("FAIL midrst_next: got %h lat %0d want %h lat %0d", bcd, lat, e.bcd, D); end
    endtask

    task automatic test_blank;
        logic [W-1:0] codes [3] = '{16'h0050, 16'h0000, 16'h0A00};
        int lat; logic [W-1:0] bcd; logic [D-1:0] mask, blank; logic err; bit b, s, a; exp_t e;
        for (int k = 0; k < 3; k++) begin
            run_word(codes[k], 2'b00, 1, 1'b0, lat, bcd, mask, err, blank, b, s, a);
            e = q.pop_front();
            tests++; if (blank !== e.blank) begin fails++; $display("FAIL blank[%0d]: got %b want %b", k, blank, e.blank); end
            tests++; if (bcd !== e.bcd) begin fails++; $display("FAIL blank_bcd[%0d]: got %h want %h", k, bcd, e.bcd); end
        end
    endtask

    task automatic test_back_to_back;
        int lat; logic [W-1:0] bcd; logic [D-1:0] mask, blank; logic err; bit b, s, a; exp_t e;
        logic [W-1:0] c; logic [1:0] m;
        for (int k = 0; k < 24; k++) begin
            c = W'($urandom); m = 2'($urandom);
            run_word(c, m, k % 3, k[0], lat, bcd, mask, err, blank, b, s, a);
            e = q.pop_front();
            tests++; if (bcd !== e.bcd || mask !== e.mask || err !== |e.mask || blank !== e.blank || lat !== D)
                begin fails++; $display("FAIL b2b[%0d] code %h mode %0d: got %h/%b/%b/%b lat %0d want %h/%b/%b/%b lat %0d",
                    k, c, m, bcd, mask, err, blank, lat, e.bcd, e.mask, |e.mask, e.blank, D); end
        end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_backpressure();
        test_reset_mid();
        test_blank();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
